// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian words from a UART byte stream,
// writes them into instruction memory through the fetch stage, then releases the core.
module prog_loader #(
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned INST_MEM_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [INST_WIDTH-1:0]     inst_in,
    output logic                      we,
    output logic                      reset_pc,
    output logic                      stall,
    output logic                      load_done,
    output logic                      load_error,
    output logic [INST_MEM_WIDTH:0]   words_loaded
);

    localparam int unsigned BytesPerWord = INST_WIDTH / 8;
    localparam int unsigned MaxBytes     = (BytesPerWord > 4) ? BytesPerWord : 4;
    localparam int unsigned CntWidth     = $clog2(MaxBytes);

    localparam logic [CntWidth-1:0] LastWordByte = CntWidth'(BytesPerWord - 1);
    localparam logic [CntWidth-1:0] LastHdrByte  = CntWidth'(3);
    localparam logic [32:0]         Capacity     = 33'(1) << INST_MEM_WIDTH;

    typedef enum logic [2:0] {
        StStart,
        StCount,
        StInst,
        StWrite,
        StFinish,
        StDone,
        StErr
    } state_e;

    state_e                    state_q, state_d;
    logic [CntWidth-1:0]       byte_cnt_q, byte_cnt_d;
    logic [INST_WIDTH-1:0]     word_q, word_d;
    logic [INST_WIDTH-1:0]     inst_q, inst_d;
    logic [31:0]               count_q, count_d;
    logic                      hdr_full_q, hdr_full_d;
    logic [INST_MEM_WIDTH:0]   words_q, words_d;
    logic                      last_word;

    // Final word of the body is being written this cycle.
    assign last_word = ((32'(words_q) + 32'd1) == count_q);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StStart;
            byte_cnt_q <= '0;
            word_q     <= '0;
            inst_q     <= '0;
            count_q    <= '0;
            hdr_full_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            inst_q     <= inst_d;
            count_q    <= count_d;
            hdr_full_q <= hdr_full_d;
            words_q    <= words_d;
        end
    end

    // Next-state logic: header capture, word assembly and write sequencing.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        inst_d     = inst_q;
        count_d    = count_q;
        hdr_full_d = hdr_full_q;
        words_d    = words_q;

        unique case (state_q)
            StStart: begin
                state_d = StCount;
            end
            StCount: begin
                if (hdr_full_q) begin
                    // Header complete last edge; evaluate N with rx ignored this cycle.
                    hdr_full_d = 1'b0;
                    byte_cnt_d = '0;
                    if ({1'b0, count_q} > Capacity) begin
                        state_d = StErr;
                    end else if (count_q == 32'd0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StInst;
                    end
                end else if (rx_valid) begin
                    count_d = {count_q[23:0], rx_data};
                    if (byte_cnt_q == LastHdrByte) begin
                        hdr_full_d = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StInst: begin
                if (rx_valid) begin
                    word_d = (word_q << 8) | INST_WIDTH'(rx_data);
                    if (byte_cnt_q == LastWordByte) begin
                        byte_cnt_d = '0;
                        state_d    = StWrite;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                words_d = words_q + 1'b1;
                inst_d  = word_q;
                if (last_word) begin
                    state_d = StFinish;
                end else begin
                    state_d = StInst;
                    // A byte arriving during the write starts the next word.
                    if (rx_valid) begin
                        word_d = (word_q << 8) | INST_WIDTH'(rx_data);
                        if (LastWordByte == '0) begin
                            byte_cnt_d = '0;
                            state_d    = StWrite;
                        end else begin
                            byte_cnt_d = CntWidth'(1);
                        end
                    end
                end
            end
            StFinish: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StStart;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        we         = 1'b0;
        reset_pc   = 1'b0;
        stall      = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        inst_in    = inst_q;

        unique case (state_q)
            StStart:  reset_pc = 1'b1;
            StCount:  stall    = 1'b1;
            StInst:   stall    = 1'b1;
            StWrite: begin
                we      = 1'b1;
                stall   = 1'b0;
                inst_in = word_q;
            end
            StFinish: reset_pc = 1'b1;
            StDone: begin
                stall     = 1'b0;
                load_done = 1'b1;
            end
            StErr:    load_error = 1'b1;
            default:  stall      = 1'b1;
        endcase
    end

    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader with hand-computed expectations.
module tb_prog_loader;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] inst_in;
    logic        we;
    logic        reset_pc;
    logic        stall;
    logic        load_done;
    logic        load_error;
    logic [10:0] words_loaded;

    int checks = 0;
    int errors = 0;

    int we_cnt = 0;
    int rpc_cnt = 0;
    int bad_stall = 0;
    logic [31:0] wlog [0:63];

    prog_loader #(
        .INST_WIDTH     (32),
        .INST_MEM_WIDTH (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .inst_in      (inst_in),
        .we           (we),
        .reset_pc     (reset_pc),
        .stall        (stall),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event log sampled mid-cycle: write pulses, reset_pc pulses, stray stall releases.
    always @(negedge clk) begin
        if (we) begin
            wlog[we_cnt % 64] = inst_in;
            we_cnt++;
        end
        if (reset_pc) rpc_cnt++;
        if (!stall && !we && !load_done) bad_stall++;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // One-cycle reset pulse; returns just after the edge that enters the count state.
    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (load_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: load_done=%b required 1 within %0d cycles",
                     name, seen, max_cycles);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (reset_pc !== 1'b1) begin errors++;
            $display("FAIL rst_reset_pc: got %b want 1", reset_pc); end
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL rst_stall: got %b want 1", stall); end
        checks++; if (we !== 1'b0) begin errors++;
            $display("FAIL rst_we: got %b want 0", we); end
        checks++; if (load_done !== 1'b0) begin errors++;
            $display("FAIL rst_load_done: got %b want 0", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++;
            $display("FAIL rst_load_error: got %b want 0", load_error); end
        checks++; if (inst_in !== 32'h0) begin errors++;
            $display("FAIL rst_inst_in: got %h want 0", inst_in); end
        checks++; if (words_loaded !== 11'd0) begin errors++;
            $display("FAIL rst_words: got %0d want 0", words_loaded); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (reset_pc !== 1'b0) begin errors++;
            $display("FAIL rel_reset_pc: got %b want 0", reset_pc); end
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL rel_stall: got %b want 1", stall); end
    endtask

    task automatic test_normal_load();
        int wb, rb, sb;
        apply_reset();
        wb = we_cnt; rb = rpc_cnt; sb = bad_stall;
        send_word(32'h0000_0002);
        idle(1);
        send_word(32'h1234_5678);
        idle(1);
        send_word(32'h9ABC_DEF0);
        @(negedge clk);
        checks++; if (we !== 1'b1 || inst_in !== 32'h9ABC_DEF0) begin errors++;
            $display("FAIL norm_write: we=%b inst=%h want we=1 inst=9abcdef0", we, inst_in); end
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL norm_write_stall: got %b want 0", stall); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (reset_pc !== 1'b1 || stall !== 1'b1 || we !== 1'b0) begin errors++;
            $display("FAIL norm_finish: reset_pc=%b stall=%b we=%b want 1 1 0",
                     reset_pc, stall, we); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (load_done !== 1'b1 || stall !== 1'b0 || reset_pc !== 1'b0) begin errors++;
            $display("FAIL norm_done: done=%b stall=%b reset_pc=%b want 1 0 0",
                     load_done, stall, reset_pc); end
        @(posedge clk);
        #1;
        checks++; if (we_cnt - wb !== 2) begin errors++;
            $display("FAIL norm_we_count: got %0d want 2", we_cnt - wb); end
        checks++; if (wlog[wb % 64] !== 32'h1234_5678) begin errors++;
            $display("FAIL norm_word0: got %h want 12345678", wlog[wb % 64]); end
        checks++; if (wlog[(wb + 1) % 64] !== 32'h9ABC_DEF0) begin errors++;
            $display("FAIL norm_word1: got %h want 9abcdef0", wlog[(wb + 1) % 64]); end
        checks++; if (rpc_cnt - rb !== 1) begin errors++;
            $display("FAIL norm_reset_pc_pulses: got %0d want 1", rpc_cnt - rb); end
        checks++; if (bad_stall - sb !== 0) begin errors++;
            $display("FAIL norm_stray_stall: got %0d want 0", bad_stall - sb); end
        checks++; if (words_loaded !== 11'd2) begin errors++;
            $display("FAIL norm_words_loaded: got %0d want 2", words_loaded); end
        checks++; if (inst_in !== 32'h9ABC_DEF0) begin errors++;
            $display("FAIL norm_inst_hold: got %h want 9abcdef0", inst_in); end
        send_word(32'h5555_5555);
        idle(2);
        checks++; if (we_cnt - wb !== 2 || load_done !== 1'b1) begin errors++;
            $display("FAIL norm_done_ignores_rx: we=%0d done=%b want 2 1", we_cnt - wb, load_done); end
    endtask

    task automatic test_zero_count();
        int wb;
        apply_reset();
        wb = we_cnt;
        send_word(32'h0000_0000);
        @(negedge clk);
        checks++; if (reset_pc !== 1'b0 || load_done !== 1'b0) begin errors++;
            $display("FAIL zero_eval: reset_pc=%b done=%b want 0 0", reset_pc, load_done); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (reset_pc !== 1'b1 || stall !== 1'b1) begin errors++;
            $display("FAIL zero_finish: reset_pc=%b stall=%b want 1 1", reset_pc, stall); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (load_done !== 1'b1 || stall !== 1'b0) begin errors++;
            $display("FAIL zero_done: done=%b stall=%b want 1 0", load_done, stall); end
        @(posedge clk);
        #1;
        checks++; if (we_cnt - wb !== 0 || words_loaded !== 11'd0) begin errors++;
            $display("FAIL zero_no_write: we=%0d words=%0d want 0 0", we_cnt - wb, words_loaded); end
    endtask

    task automatic test_overflow();
        int wb;
        apply_reset();
        wb = we_cnt;
        send_word(32'h0000_0401);
        idle(1);
        @(negedge clk);
        checks++; if (load_error !== 1'b1 || stall !== 1'b1) begin errors++;
            $display("FAIL ovf_error: err=%b stall=%b want 1 1", load_error, stall); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(8'h55);
        idle(3);
        @(negedge clk);
        checks++; if (load_error !== 1'b1 || stall !== 1'b1 || load_done !== 1'b0) begin errors++;
            $display("FAIL ovf_sticky: err=%b stall=%b done=%b want 1 1 0",
                     load_error, stall, load_done); end
        @(posedge clk);
        #1;
        checks++; if (we_cnt - wb !== 0) begin errors++;
            $display("FAIL ovf_no_write: got %0d want 0", we_cnt - wb); end
    endtask

    task automatic test_back_to_back();
        int wb;
        apply_reset();
        wb = we_cnt;
        send_word(32'h0000_0002);
        idle(1);
        send_word(32'h1122_3344);
        // Now in the write cycle: this byte must start the next word.
        send_word(32'hAABB_CCDD);
        wait_done(10, "b2b");
        checks++; if (we_cnt - wb !== 2) begin errors++;
            $display("FAIL b2b_we_count: got %0d want 2", we_cnt - wb); end
        checks++; if (wlog[wb % 64] !== 32'h1122_3344) begin errors++;
            $display("FAIL b2b_word0: got %h want 11223344", wlog[wb % 64]); end
        checks++; if (wlog[(wb + 1) % 64] !== 32'hAABB_CCDD) begin errors++;
            $display("FAIL b2b_word1: got %h want aabbccdd", wlog[(wb + 1) % 64]); end
    endtask

    task automatic test_reset_mid_word();
        int wb;
        apply_reset();
        send_word(32'h0000_0001);
        idle(1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        wb = we_cnt;
        apply_reset();
        send_word(32'h0000_0001);
        idle(1);
        send_word(32'hCAFE_BABE);
        wait_done(10, "midrst");
        checks++; if (we_cnt - wb !== 1) begin errors++;
            $display("FAIL midrst_we_count: got %0d want 1", we_cnt - wb); end
        checks++; if (wlog[wb % 64] !== 32'hCAFE_BABE) begin errors++;
            $display("FAIL midrst_word: got %h want cafebabe", wlog[wb % 64]); end
        checks++; if (words_loaded !== 11'd1) begin errors++;
            $display("FAIL midrst_words: got %0d want 1", words_loaded); end
    endtask

    task automatic test_full_capacity();
        int wb, rb, sb;
        apply_reset();
        wb = we_cnt; rb = rpc_cnt; sb = bad_stall;
        send_word(32'h0000_0400);
        idle(1);
        for (int i = 0; i < 1024; i++) send_word(32'(i) ^ 32'hA500_0000);
        wait_done(10, "full");
        checks++; if (we_cnt - wb !== 1024) begin errors++;
            $display("FAIL full_we_count: got %0d want 1024", we_cnt - wb); end
        checks++; if (wlog[(we_cnt - 1) % 64] !== 32'hA500_03FF) begin errors++;
            $display("FAIL full_last_word: got %h want a50003ff", wlog[(we_cnt - 1) % 64]); end
        checks++; if (words_loaded !== 11'd1024) begin errors++;
            $display("FAIL full_words: got %0d want 1024", words_loaded); end
        checks++; if (load_error !== 1'b0) begin errors++;
            $display("FAIL full_no_error: got %b want 0", load_error); end
        checks++; if (rpc_cnt - rb !== 1 || bad_stall - sb !== 0) begin errors++;
            $display("FAIL full_pc_ctrl: reset_pc pulses=%0d stray=%0d want 1 0",
                     rpc_cnt - rb, bad_stall - sb); end
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_normal_load();
        test_zero_count();
        test_overflow();
        test_back_to_back();
        test_reset_mid_word();
        test_full_capacity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory / fetch stage.
- Consumes the byte stream from the UART receiver and assembles big-endian instruction words.
- Drives the fetch stage's write port (inst_in, we), its PC control (reset_pc, stall), and a done flag.
- Once the program is in memory, zeroes the PC and releases the core.

Parameters:
INST_WIDTH, 32, instruction word width in bits; must be a multiple of 8
INST_MEM_WIDTH, 10, instruction memory address width; capacity 2**INST_MEM_WIDTH words

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
rx_data  in  8  received byte from UART
rx_valid  in  1  one-cycle strobe, rx_data valid
inst_in  out  INST_WIDTH  assembled instruction word to fetch stage
we  out  1  write strobe to instruction memory (writes at current PC)
reset_pc  out  1  forces fetch PC to 0
stall  out  1  holds fetch PC; 0 only when PC may advance
load_done  out  1  program loaded, core running
load_error  out  1  instruction count exceeds capacity
words_loaded  out  INST_MEM_WIDTH+1  number of words written so far

Behaviour:
- Single clock domain. All state updates on posedge clk. reset_n is sampled synchronously; 0 forces the reset state.
- Outputs are decoded from registered state and registers only; no combinational path from rx_* to outputs.
- State reset values: state=S_START, byte counter=0, word shift register=0, words_loaded=0, count register=0.
- Output values in S_START: reset_pc=1, stall=1, we=0, load_done=0, load_error=0, inst_in=0.
- Header: first 4 received bytes form a 32-bit big-endian instruction count N.
- Body: N words follow, each INST_WIDTH/8 bytes, big-endian (first byte -> bits [INST_WIDTH-1:INST_WIDTH-8]).
- States:
  - S_START: reset_pc=1, stall=1. Next cycle -> S_COUNT unconditionally. An rx_valid byte here is ignored.
  - S_COUNT: stall=1. Each rx_valid shifts the byte into the count register.
    - After the 4th byte, N is evaluated on the next edge.
    - N > 2**INST_MEM_WIDTH -> S_ERR.
    - N == 0 -> S_FINISH.
    - Otherwise -> S_INST.
  - S_INST: stall=1. Each rx_valid shifts the byte into the word register.
    - On the byte completing a word -> S_WRITE.
  - S_WRITE: exactly one cycle. we=1, stall=0, inst_in=assembled word.
    - The fetch stage writes mem[PC] and increments PC at the end of this cycle.
    - words_loaded increments at the end of this cycle.
    - If words_loaded+1 == N -> S_FINISH, else -> S_INST.
    - An rx_valid in this cycle is accepted as byte 0 of the next word; the byte counter restarts so it is not lost.
  - S_FINISH: one cycle. reset_pc=1, stall=1. Next -> S_DONE.
  - S_DONE: stall=0, load_done=1, we=0. Terminal until reset_n; rx_valid ignored (the core owns the UART).
  - S_ERR: stall=1, load_error=1, we=0. Terminal until reset_n; rx_valid ignored.
- inst_in holds the last written word outside S_WRITE.
- Latency: last byte of a word at cycle t -> we=1 at t+1 -> PC advanced at t+2.
- Last body byte at t -> S_WRITE at t+1, S_FINISH at t+2, load_done=1 at t+3.
- N == 2**INST_MEM_WIDTH is legal. The PC wraps to 0 after the final write; S_FINISH still asserts reset_pc.
- reset_n low mid-load returns to S_START immediately at the next edge. Partial words are discarded; the stream must restart from the header.
- Byte counter width: enough bits for max(4, INST_WIDTH/8) bytes. words_loaded width INST_MEM_WIDTH+1 so a full memory is representable.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> reset_pc=1, stall=1, we=0, load_done=0; one cycle after release, reset_pc=0 in S_COUNT.
- Normal load: header 00 00 00 02, then words 12 34 56 78 and 9A BC DE F0 -> two single-cycle we pulses with inst_in=0x12345678 then 0x9ABCDEF0, stall=0 only in those cycles, one reset_pc pulse, then load_done=1 and words_loaded=2.
- Zero count: header 00 00 00 00 -> no we pulse; reset_pc pulse 1 cycle after S_COUNT exit; load_done=1 next cycle.
- Overflow: INST_MEM_WIDTH=10, header 00 00 04 01 (1025) -> load_error=1, stall=1 permanently, further bytes produce no we.
- Back-to-back byte: rx_valid asserted in the S_WRITE cycle with 0xAA -> next written word has bits[31:24]=0xAA.
- Reset mid-word: after 2 body bytes pull reset_n low 1 cycle, then send a full fresh stream of N=1, word 0xCAFEBABE -> exactly one we with 0xCAFEBABE, load_done=1.
